// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve countdown, play gating, point/win detection.
// Optional pause/resume support is built when PONG_PAUSE_EN is defined.
module pong_match_controller #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_start_btn,
    input  logic       i_pause_btn,
    input  logic [3:0] i_score1,
    input  logic [3:0] i_score2,
    output logic       o_logic_en,
    output logic       o_logic_rst,
    output logic [2:0] o_state,
    output logic [1:0] o_winner,
    output logic [7:0] o_countdown
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WIN_W   = 2;

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_LVL    = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_countdown;
    logic [CNT_W-1:0]   w_countdown_nxt;
    logic [WIN_W-1:0]   r_winner;
    logic [WIN_W-1:0]   w_winner_nxt;
    logic               r_logic_en;
    logic               w_logic_en_nxt;
    logic               r_logic_rst;
    logic               r_start_q;
    logic [SCORE_W-1:0] r_s1_q;
    logic [SCORE_W-1:0] r_s2_q;
    logic               w_start_edge;
    logic               w_score_chg;

    assign w_start_edge = i_start_btn & ~r_start_q;
    assign w_score_chg  = (i_score1 != r_s1_q) | (i_score2 != r_s2_q);

`ifdef PONG_PAUSE_EN
    logic r_pause_q;
    logic r_ret_play;
    logic w_ret_play_nxt;
    logic w_pause_edge;

    assign w_pause_edge = i_pause_btn & ~r_pause_q;

    // Pause button history and the state to resume into (0 SERVE, 1 PLAY)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pause_q  <= 1'b0;
            r_ret_play <= 1'b0;
        end else begin
            r_pause_q  <= i_pause_btn;
            r_ret_play <= w_ret_play_nxt;
        end
    end
`else
    logic w_unused_pause;
    assign w_unused_pause = i_pause_btn;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_countdown_nxt = r_countdown;
        w_winner_nxt    = r_winner;
        w_logic_en_nxt  = 1'b0;
`ifdef PONG_PAUSE_EN
        w_ret_play_nxt  = r_ret_play;
`endif
        case (r_state)
            ST_IDLE: begin
                w_winner_nxt = '0;
                if (w_start_edge) begin
                    w_state_nxt     = ST_SERVE;
                    w_countdown_nxt = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
`ifdef PONG_PAUSE_EN
                if (w_pause_edge) begin
                    w_state_nxt    = ST_PAUSE;
                    w_ret_play_nxt = 1'b0;
                end else
`endif
                if (r_countdown == '0) begin
                    w_state_nxt = ST_PLAY;
                end else if (i_frame_tick) begin
                    w_countdown_nxt = r_countdown - CNT_W'(1);
                    if (r_countdown == CNT_W'(1)) begin
                        w_state_nxt = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                w_logic_en_nxt = i_frame_tick;
                // A point takes precedence over a simultaneous pause request
                if (w_score_chg) begin
                    if (i_score1 >= WIN_LVL) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = WIN_W'(1);
                    end else if (i_score2 >= WIN_LVL) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = WIN_W'(2);
                    end else begin
                        w_state_nxt     = ST_SERVE;
                        w_countdown_nxt = SERVE_LOAD;
                    end
                end
`ifdef PONG_PAUSE_EN
                else if (w_pause_edge) begin
                    w_state_nxt    = ST_PAUSE;
                    w_ret_play_nxt = 1'b1;
                end
`endif
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (w_pause_edge) begin
                    w_state_nxt = r_ret_play ? ST_PLAY : ST_SERVE;
                end
            end
`endif
            ST_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt  = ST_IDLE;
                    w_winner_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, output and input-history registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_countdown <= '0;
            r_winner    <= '0;
            r_logic_en  <= 1'b0;
            r_logic_rst <= 1'b1;
            r_start_q   <= 1'b0;
            r_s1_q      <= '0;
            r_s2_q      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_countdown <= w_countdown_nxt;
            r_winner    <= w_winner_nxt;
            r_logic_en  <= w_logic_en_nxt;
            r_logic_rst <= (w_state_nxt == ST_IDLE);
            r_start_q   <= i_start_btn;
            r_s1_q      <= i_score1;
            r_s2_q      <= i_score2;
        end
    end

    assign o_state     = r_state;
    assign o_countdown = r_countdown;
    assign o_winner    = r_winner;
    assign o_logic_en  = r_logic_en;
    assign o_logic_rst = r_logic_rst;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed self-checking bench for pong_match_controller.
// Three instances share stimulus: SERVE_FRAMES of 60 (a), 3 (b) and 0 (z).
module tb_pong_match_controller;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start_btn, pause_btn;
    logic [3:0] score1, score2;

    logic       a_en, a_rst, b_en, b_rst, z_en, z_rst;
    logic [2:0] a_state, b_state, z_state;
    logic [1:0] a_win, b_win, z_win;
    logic [7:0] a_cd, b_cd, z_cd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pong_match_controller #(.SERVE_FRAMES(60), .WIN_SCORE(7)) u_a (
        .i_clk(clk), .i_reset(reset), .i_frame_tick(frame_tick),
        .i_start_btn(start_btn), .i_pause_btn(pause_btn),
        .i_score1(score1), .i_score2(score2),
        .o_logic_en(a_en), .o_logic_rst(a_rst), .o_state(a_state),
        .o_winner(a_win), .o_countdown(a_cd));

    pong_match_controller #(.SERVE_FRAMES(3), .WIN_SCORE(7)) u_b (
        .i_clk(clk), .i_reset(reset), .i_frame_tick(frame_tick),
        .i_start_btn(start_btn), .i_pause_btn(pause_btn),
        .i_score1(score1), .i_score2(score2),
        .o_logic_en(b_en), .o_logic_rst(b_rst), .o_state(b_state),
        .o_winner(b_win), .o_countdown(b_cd));

    pong_match_controller #(.SERVE_FRAMES(0), .WIN_SCORE(7)) u_z (
        .i_clk(clk), .i_reset(reset), .i_frame_tick(frame_tick),
        .i_start_btn(start_btn), .i_pause_btn(pause_btn),
        .i_score1(score1), .i_score2(score2),
        .o_logic_en(z_en), .o_logic_rst(z_rst), .o_state(z_state),
        .o_winner(z_win), .o_countdown(z_cd));

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        score1 = 4'd0; score2 = 4'd0;
        step(); step();
        reset = 1'b0;
    endtask

    // Start, then three tick pulses: instance b ends in PLAY
    task automatic reach_play_b();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (a_state !== 3'd0) begin failures++; $display("FAIL reset_state act=%0d exp=0", a_state); end
        checks++; if (a_rst !== 1'b1) begin failures++; $display("FAIL reset_logic_rst act=%0b exp=1", a_rst); end
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL reset_logic_en act=%0b exp=0", a_en); end
        checks++; if (a_cd !== 8'd0 || a_win !== 2'd0) begin failures++; $display("FAIL reset_cd_win act=%0d/%0d exp=0/0", a_cd, a_win); end
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (a_state !== 3'd1) begin failures++; $display("FAIL start_state act=%0d exp=1", a_state); end
        checks++; if (a_cd !== 8'd60) begin failures++; $display("FAIL start_countdown act=%0d exp=60", a_cd); end
        checks++; if (a_rst !== 1'b0) begin failures++; $display("FAIL start_logic_rst act=%0b exp=0", a_rst); end
    endtask

    task automatic test_serve_countdown();
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (b_cd !== 8'd3) begin failures++; $display("FAIL serve_load act=%0d exp=3", b_cd); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_cd !== 8'd2 || b_state !== 3'd1) begin failures++; $display("FAIL serve_tick1 act=%0d/%0d exp=2/1", b_cd, b_state); end
        step();
        checks++; if (b_cd !== 8'd2 || b_en !== 1'b0) begin failures++; $display("FAIL serve_hold act=%0d/%0b exp=2/0", b_cd, b_en); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_cd !== 8'd1 || b_state !== 3'd1) begin failures++; $display("FAIL serve_tick2 act=%0d/%0d exp=1/1", b_cd, b_state); end
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (b_state !== 3'd1 || b_rst !== 1'b0) begin failures++; $display("FAIL serve_start_ignored act=%0d exp=1", b_state); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_cd !== 8'd0 || b_state !== 3'd2 || b_en !== 1'b0) begin failures++; $display("FAIL serve_expire act=%0d/%0d/%0b exp=0/2/0", b_cd, b_state, b_en); end
        step();
        checks++; if (b_en !== 1'b0) begin failures++; $display("FAIL play_entry_no_en act=%0b exp=0", b_en); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_en !== 1'b1) begin failures++; $display("FAIL play_en_pulse act=%0b exp=1", b_en); end
        step();
        checks++; if (b_en !== 1'b0) begin failures++; $display("FAIL play_en_single act=%0b exp=0", b_en); end
    endtask

    task automatic test_zero_serve();
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (z_state !== 3'd1 || z_cd !== 8'd0) begin failures++; $display("FAIL zero_serve_entry act=%0d/%0d exp=1/0", z_state, z_cd); end
        step();
        checks++; if (z_state !== 3'd2) begin failures++; $display("FAIL zero_serve_play act=%0d exp=2", z_state); end
    endtask

    task automatic test_point();
        do_reset();
        reach_play_b();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (b_state !== 3'd2) begin failures++; $display("FAIL play_start_ignored act=%0d exp=2", b_state); end
        score2 = 4'd1; step();
        checks++; if (b_state !== 3'd1 || b_cd !== 8'd3) begin failures++; $display("FAIL point_reserve act=%0d/%0d exp=1/3", b_state, b_cd); end
        checks++; if (b_win !== 2'd0) begin failures++; $display("FAIL point_winner act=%0d exp=0", b_win); end
        for (int i = 0; i < 2; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        checks++; if (b_state !== 3'd1 || b_cd !== 8'd1) begin failures++; $display("FAIL point_freeze act=%0d/%0d exp=1/1", b_state, b_cd); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_state !== 3'd2) begin failures++; $display("FAIL point_resume act=%0d exp=2", b_state); end
    endtask

    task automatic test_win();
        do_reset();
        score1 = 4'd6; step();
        reach_play_b();
        score1 = 4'd7; step();
        checks++; if (b_state !== 3'd4 || b_win !== 2'd1) begin failures++; $display("FAIL win_p1 act=%0d/%0d exp=4/1", b_state, b_win); end
        for (int i = 0; i < 2; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            checks++; if (b_en !== 1'b0 || b_win !== 2'd1) begin failures++; $display("FAIL over_no_en act=%0b/%0d exp=0/1", b_en, b_win); end
        end
        start_btn = 1'b1; step(); start_btn = 1'b0;
        checks++; if (b_state !== 3'd0 || b_rst !== 1'b1 || b_win !== 2'd0) begin failures++; $display("FAIL over_restart act=%0d/%0b/%0d exp=0/1/0", b_state, b_rst, b_win); end

        do_reset();
        score1 = 4'd3; score2 = 4'd6; step();
        reach_play_b();
        score2 = 4'd7; step();
        checks++; if (b_state !== 3'd4 || b_win !== 2'd2) begin failures++; $display("FAIL win_p2 act=%0d/%0d exp=4/2", b_state, b_win); end

        do_reset();
        score1 = 4'd6; score2 = 4'd6; step();
        reach_play_b();
        score1 = 4'd7; score2 = 4'd7; step();
        checks++; if (b_state !== 3'd4 || b_win !== 2'd1) begin failures++; $display("FAIL win_tie_p1 act=%0d/%0d exp=4/1", b_state, b_win); end
    endtask

    task automatic test_pause();
`ifdef PONG_PAUSE_EN
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        frame_tick = 1'b1;
        repeat (40) step();
        checks++; if (a_cd !== 8'd20) begin failures++; $display("FAIL pause_pre_cd act=%0d exp=20", a_cd); end
        pause_btn = 1'b1; step(); pause_btn = 1'b0; frame_tick = 1'b0;
        checks++; if (a_state !== 3'd3 || a_cd !== 8'd20) begin failures++; $display("FAIL pause_enter act=%0d/%0d exp=3/20", a_state, a_cd); end
        for (int i = 0; i < 5; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            checks++; if (a_state !== 3'd3 || a_cd !== 8'd20 || a_en !== 1'b0) begin failures++; $display("FAIL pause_hold act=%0d/%0d/%0b exp=3/20/0", a_state, a_cd, a_en); end
        end
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        checks++; if (a_state !== 3'd1 || a_cd !== 8'd20) begin failures++; $display("FAIL pause_resume_serve act=%0d/%0d exp=1/20", a_state, a_cd); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (a_cd !== 8'd19) begin failures++; $display("FAIL pause_after_cd act=%0d exp=19", a_cd); end

        do_reset();
        reach_play_b();
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        checks++; if (b_state !== 3'd3) begin failures++; $display("FAIL pause_play_enter act=%0d exp=3", b_state); end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        checks++; if (b_en !== 1'b0) begin failures++; $display("FAIL pause_play_no_en act=%0b exp=0", b_en); end
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        checks++; if (b_state !== 3'd2) begin failures++; $display("FAIL pause_resume_play act=%0d exp=2", b_state); end
        step();
        pause_btn = 1'b1; score2 = 4'd1; step(); pause_btn = 1'b0;
        checks++; if (b_state !== 3'd1 || b_cd !== 8'd3) begin failures++; $display("FAIL pause_vs_point act=%0d/%0d exp=1/3", b_state, b_cd); end
`else
        do_reset();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        pause_btn = 1'b1; frame_tick = 1'b1; step(); pause_btn = 1'b0; frame_tick = 1'b0;
        checks++; if (a_state !== 3'd1 || a_cd !== 8'd59) begin failures++; $display("FAIL nopause_serve act=%0d/%0d exp=1/59", a_state, a_cd); end

        do_reset();
        reach_play_b();
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        checks++; if (b_state !== 3'd2) begin failures++; $display("FAIL nopause_play act=%0d exp=2", b_state); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        reach_play_b();
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (b_state !== 3'd0 || b_rst !== 1'b1 || b_win !== 2'd0 || b_cd !== 8'd0) begin failures++; $display("FAIL midplay_reset act=%0d/%0b/%0d/%0d exp=0/1/0/0", b_state, b_rst, b_win, b_cd); end
        checks++; if (a_state !== 3'd0 || a_cd !== 8'd0) begin failures++; $display("FAIL midserve_reset act=%0d/%0d exp=0/0", a_state, a_cd); end

        do_reset();
        reach_play_b();
        score1 = 4'd7; step();
        reset = 1'b1; start_btn = 1'b1; step(); reset = 1'b0; start_btn = 1'b0;
        checks++; if (b_state !== 3'd0 || b_win !== 2'd0 || b_rst !== 1'b1) begin failures++; $display("FAIL over_reset act=%0d/%0d/%0b exp=0/0/1", b_state, b_win, b_rst); end
    endtask

    initial begin
        test_reset();
        test_serve_countdown();
        test_zero_serve();
        test_point();
        test_win();
        test_pause();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_match_controller.md
# pong_match_controller

Match sequencer for the Pong core. It gates the per-frame update of the game-logic datapath, holds the ball frozen during a serve countdown, and detects points from the score outputs. It also declares a winner at a configurable score and supports pause/resume. It sits between the board buttons and video frame tick on one side and the game-logic block's enable and reset inputs on the other.

## Interface
- `SERVE_FRAMES`, default 60: frame ticks the ball stays frozen before each serve (8-bit range, 0 allowed).
- `WIN_SCORE`, default 7: score (1–15) at which a player wins.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock domain.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: start/restart button, level; already synchronized and debounced.
- `pause_btn` in 1: pause toggle button, level; already synchronized and debounced.
- `score1` in 4: player-1 score from game logic.
- `score2` in 4: player-2 score from game logic.
- `logic_en` out 1: one-cycle update strobe to game logic.
- `logic_rst` out 1: level reset to game logic; clears scores and positions.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
- `winner` out 2: 0 none, 1 player 1, 2 player 2.
- `countdown` out 8: remaining serve frames.

## Operation
- Rising edges are `btn & ~btn_q`. The `_q` registers sample every cycle and clear on reset.
- Score-change detect is `(score1 != s1_q) | (score2 != s2_q)`. `s1_q`/`s2_q` sample every cycle.
- **IDLE**
  - `logic_rst`=1, `winner`=0.
  - Start edge: go to SERVE and load `countdown`=SERVE_FRAMES.
- **SERVE**
  - `logic_en`=0.
  - Each `frame_tick` with `countdown`>1 decrements `countdown`.
  - A `frame_tick` with `countdown`==1 sets `countdown`=0 and goes to PLAY.
  - If `countdown`==0 on entry, go to PLAY the next cycle without waiting for a tick.
- **PLAY**
  - A `frame_tick` produces `logic_en`.
  - Score change with `score1`>=WIN_SCORE: go to OVER, `winner`=1.
  - Otherwise, `score2`>=WIN_SCORE: go to OVER, `winner`=2.
  - Otherwise, any score change: go to SERVE, reload `countdown`.
- **PAUSE**
  - `logic_en`=0 and `countdown` is held.
  - A pause edge in SERVE or PLAY enters PAUSE and stores the return state (1 bit).
  - A pause edge in PAUSE returns to the stored state.
- **OVER**
  - `logic_en`=0 and `winner` is held.
  - Start edge: go to IDLE.
- **Priorities within one cycle:**
  - `reset` overrides everything.
  - In PLAY, a score change overrides a pause edge; the pause edge is dropped.
  - In SERVE, a pause edge overrides countdown expiry; `countdown` is not decremented that cycle.
  - Start edges are ignored outside IDLE and OVER.
  - Pause edges are ignored in IDLE and OVER.
- Score comparisons are unsigned 4-bit. Scores of 15 or more never wrap in the controller, because OVER is reached first for any WIN_SCORE≤15.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `logic_rst`=1, `logic_en`=0, `winner`=0, `countdown`=0, all edge and score history registers 0.
- `logic_rst` is registered from next-state==IDLE. It rises the cycle IDLE is entered and falls the cycle SERVE is entered.
- `logic_en` latency: asserted the cycle after a `frame_tick` sampled in PLAY, for exactly one cycle. A tick in the same cycle PLAY is entered does not fire.
- Score-change latency: a score update caused by `logic_en` in cycle N is seen in cycle N+1. The state changes at the end of N+1.
- PLAY→SERVE→PLAY takes exactly SERVE_FRAMES frame ticks of freeze.
- Reset mid-match returns to IDLE on the next edge and asserts `logic_rst`. The game logic is cleared regardless of state.

## Configuration
- `PONG_PAUSE_EN` defined:
  - PAUSE state, `pause_btn` edge detect and the return-state register are present.
  - Behaviour as described above.
- `PONG_PAUSE_EN` undefined:
  - `pause_btn` is ignored and PAUSE is unreachable.
  - `state` never reads 3, and no pause logic is synthesized.

## Test plan
- **Reset and start:** reset, then hold `start_btn`=0. Expect `state`=0, `logic_rst`=1, `logic_en`=0. Then pulse start: `state`=1, `countdown`=60, `logic_rst`=0 the following cycle.
- **Serve countdown:** with SERVE_FRAMES=3, give 3 ticks. Expect `countdown` 3→2→1→0, `state`=2 after the third tick, and no `logic_en` during SERVE. The next tick gives a `logic_en` one cycle later.
- **Point scored:** in PLAY, change `score2` from 0 to 1. The next cycle expect `state`=1 and `countdown`=SERVE_FRAMES.
- **Win:** with WIN_SCORE=7 and `score1` 6→7 in PLAY, expect `state`=4 and `winner`=1. Later tick pulses give no `logic_en`. A start edge gives `state`=0 and `logic_rst`=1.
- **Pause:**
  - Pause edge in SERVE at `countdown`=20: expect `state`=3 and `countdown` stays 20 through 5 ticks.
  - A second pause edge returns to `state`=1.
  - A pause edge in the same cycle as a score change in PLAY is ignored (goes to SERVE).
  - With `PONG_PAUSE_EN` undefined, a pause edge leaves `state` unchanged.
- **Mid-play reset:** reset during PLAY. Expect `state`=0, `logic_rst`=1, `winner`=0, `countdown`=0 after one edge.
